// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// The table geometry (address width, index/tag/counter widths) is set here;
// branch_predictor's parameters default to these values and must match them.
package bp_pkg;

  localparam int BP_XLEN     = 32;
  localparam int BP_IDX_BITS = 6;
  localparam int BP_TAG_BITS = 8;
  localparam int BP_CNT_BITS = 2;

  // One predictor table entry.
  typedef struct packed {
    logic                   valid;
    logic [BP_TAG_BITS-1:0] tag;
    logic [BP_XLEN-1:0]     target;
    logic                   jump;
    logic [BP_CNT_BITS-1:0] cnt;
  } bp_entry_t;

  // Direction counter landmarks: weakly taken = 10..0, weakly not-taken = 01..1.
  localparam logic [BP_CNT_BITS-1:0] CNT_WEAK_T  = {1'b1, {(BP_CNT_BITS-1){1'b0}}};
  localparam logic [BP_CNT_BITS-1:0] CNT_WEAK_NT = {1'b0, {(BP_CNT_BITS-1){1'b1}}};
  localparam logic [BP_CNT_BITS-1:0] CNT_MAX     = {BP_CNT_BITS{1'b1}};

  // Table index: word-address bits just above the byte offset.
  function automatic logic [BP_IDX_BITS-1:0] pc_index(input logic [BP_XLEN-1:0] pc);
    return BP_IDX_BITS'(pc >> 2);
  endfunction

  // Stored tag: the bits immediately above the index.
  function automatic logic [BP_TAG_BITS-1:0] pc_tag(input logic [BP_XLEN-1:0] pc);
    return BP_TAG_BITS'(pc >> (BP_IDX_BITS + 2));
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter next-value logic for the direction counters.
// Purely combinational; the predictor table holds the counter state.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int CNT_BITS = BP_CNT_BITS
) (
  input  logic [CNT_BITS-1:0] cnt_in,
  input  logic                inc,
  output logic [CNT_BITS-1:0] cnt_out
);

  // Step toward taken on inc, toward not-taken otherwise; hold at the rails.
  always_comb begin
    cnt_out = cnt_in;
    if (inc) begin
      if (cnt_in != CNT_MAX) cnt_out = cnt_in + CNT_BITS'(1);
    end else begin
      if (cnt_in != '0) cnt_out = cnt_in - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// direction counters. Lookup in IF is combinational from the registered
// table; training and mispredict/redirect come from the resolved EX instruction.
// Optional feature macro: BP_PERF_EN adds three 32-bit performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = BP_XLEN,
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int TAG_BITS = BP_TAG_BITS,
  parameter int CNT_BITS = BP_CNT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  // IF-stage lookup
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  // EX-stage resolution
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_PERF_EN
  ,
  output logic [31:0]     perf_lookups,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  // ex_valid qualifies every EX field: it is high for exactly one cycle per
  // real instruction (the caller drops it for bubbles and stalls), so each
  // cycle with ex_valid=1 trains the table and counts once, with no backpressure.

  bp_entry_t tbl [ENTRIES];

  logic [IDX_BITS-1:0] l_idx;
  logic [TAG_BITS-1:0] l_tag;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_BITS-1:0] u_tag;
  logic                is_cf;
  logic                act_taken;
  logic                u_hit;
  logic                alias_clr;
  logic [CNT_BITS-1:0] cnt_next;

  assign l_idx = pc_index(if_pc);
  assign l_tag = pc_tag(if_pc);
  assign u_idx = pc_index(ex_pc);
  assign u_tag = pc_tag(ex_pc);

  // IF lookup: reads the registered table, so a same-cycle update is not seen.
  always_comb begin
    pred_hit    = tbl[l_idx].valid && (tbl[l_idx].tag == l_tag);
    pred_taken  = pred_hit && (tbl[l_idx].jump || tbl[l_idx].cnt[CNT_BITS-1]);
    pred_target = pred_taken ? tbl[l_idx].target : if_pc + XLEN'(4);
  end

  // EX resolution: compare actual outcome with the prediction carried down the pipe.
  always_comb begin
    is_cf       = ex_is_branch || ex_is_jump;
    act_taken   = ex_valid && is_cf && ex_taken;
    mispredict  = ex_valid && ((act_taken != ex_pred_taken) ||
                               (act_taken && (ex_target != ex_pred_target)));
    redirect_pc = act_taken ? ex_target : ex_pc + XLEN'(4);
    u_hit       = tbl[u_idx].valid && (tbl[u_idx].tag == u_tag);
    // A taken prediction on a non-control-flow instruction came from an aliased entry.
    alias_clr   = ex_valid && !is_cf && ex_pred_taken;
  end

  bp_sat_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_sat_counter (
    .cnt_in (tbl[u_idx].cnt),
    .inc    (act_taken),
    .cnt_out(cnt_next)
  );

  // Table training: refresh on hit, allocate on taken miss, drop aliased entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, jump: 1'b0, cnt: CNT_WEAK_NT};
      end
    end else if (ex_valid && is_cf) begin
      if (u_hit) begin
        tbl[u_idx].target <= ex_target;
        tbl[u_idx].jump   <= ex_is_jump;
        tbl[u_idx].cnt    <= cnt_next;
      end else if (act_taken) begin
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: ex_target,
                        jump: ex_is_jump, cnt: CNT_WEAK_T};
      end
    end else if (alias_clr) begin
      tbl[u_idx].valid <= 1'b0;
    end
  end

`ifdef BP_PERF_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lookups     <= '0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      perf_lookups <= perf_lookups + 32'd1;
      if (ex_valid && is_cf) perf_branches <= perf_branches + 32'd1;
      if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a
// randomized run, all checked against a table model kept in plain arrays.
module tb_branch_predictor;

  localparam int XLEN     = 32;
  localparam int IDX_BITS = 6;
  localparam int TAG_BITS = 8;
  localparam int CNT_BITS = 2;
  localparam int NE       = 1 << IDX_BITS;
  localparam int CMAX     = (1 << CNT_BITS) - 1;
  localparam int HALF     = 1 << (CNT_BITS - 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] if_pc;
  logic            pred_hit, pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
  logic [XLEN-1:0] ex_pc, ex_target, ex_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
`ifdef BP_PERF_EN
  logic [31:0]     perf_lookups, perf_branches, perf_mispredicts;
`endif

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  branch_predictor #(
    .XLEN(XLEN), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_PERF_EN
    , .perf_lookups(perf_lookups), .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
`endif
  );

  // ---------------- reference model ----------------
  bit              m_valid  [NE];
  int unsigned     m_tag    [NE];
  logic [XLEN-1:0] m_target [NE];
  bit              m_jump   [NE];
  int              m_cnt    [NE];
  int unsigned     m_lookups, m_branches, m_mispredicts;

  always @(posedge clk) if (!rst) m_lookups++;

  function automatic int midx(input logic [XLEN-1:0] pc);
    return int'((pc >> 2) % NE);
  endfunction

  function automatic int unsigned mtag(input logic [XLEN-1:0] pc);
    return (pc >> (IDX_BITS + 2)) % (1 << TAG_BITS);
  endfunction

  function automatic bit m_hit(input logic [XLEN-1:0] pc);
    return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
  endfunction

  function automatic bit m_taken(input logic [XLEN-1:0] pc);
    return m_hit(pc) && (m_jump[midx(pc)] || (m_cnt[midx(pc)] >= HALF));
  endfunction

  function automatic logic [XLEN-1:0] m_ptarget(input logic [XLEN-1:0] pc);
    return m_taken(pc) ? m_target[midx(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_act();
    return ex_valid && (ex_is_branch || ex_is_jump) && ex_taken;
  endfunction

  function automatic bit m_misp();
    return ex_valid && ((m_act() != ex_pred_taken) ||
                        (m_act() && (ex_target != ex_pred_target)));
  endfunction

  function automatic logic [XLEN-1:0] m_redirect();
    return m_act() ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NE; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = 0;
      m_target[i] = '0;
      m_jump[i]   = 1'b0;
      m_cnt[i]    = HALF - 1;
    end
    m_lookups = 0; m_branches = 0; m_mispredicts = 0;
  endtask

  // Apply what the predictor must learn from the EX instruction this cycle.
  task automatic model_commit();
    int i;
    i = midx(ex_pc);
    if (m_misp()) m_mispredicts++;
    if (ex_valid && (ex_is_branch || ex_is_jump)) begin
      m_branches++;
      if (m_hit(ex_pc)) begin
        m_target[i] = ex_target;
        m_jump[i]   = ex_is_jump;
        if (m_act()) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        else         m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (m_act()) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = mtag(ex_pc);
        m_target[i] = ex_target;
        m_jump[i]   = ex_is_jump;
        m_cnt[i]    = HALF;
      end
    end else if (ex_valid && ex_pred_taken) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ex(input bit v, input logic [XLEN-1:0] pc, input bit br,
                        input bit jmp, input bit tk, input logic [XLEN-1:0] tgt,
                        input bit pt, input logic [XLEN-1:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jump = jmp;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    set_ex(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // EX instruction carrying whatever the predictor would have said for it in IF.
  task automatic ex_carried(input logic [XLEN-1:0] pc, input bit br, input bit jmp,
                            input bit tk, input logic [XLEN-1:0] tgt);
    set_ex(1'b1, pc, br, jmp, tk, tgt, m_taken(pc), m_ptarget(pc));
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ex_idle(); if_pc = 32'h40;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL reset_hit: got %b expected 0", pred_hit); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken: got %b expected 0", pred_taken); end
    total++; if (pred_target !== 32'h44) begin bad++; $display("FAIL reset_target: got %h expected 00000044", pred_target); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_misp: got %b expected 0", mispredict); end
    advance();
  endtask

  task automatic test_train_taken();
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    if_pc = 32'h40;
    @(negedge clk);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL train_misp: got %b expected 1", mispredict); end
    total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL train_redirect: got %h expected 00000080", redirect_pc); end
    advance();
    ex_idle(); if_pc = 32'h100;
    @(negedge clk);
    total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL train_hit: got %b expected 1", pred_hit); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL train_taken: got %b expected 1", pred_taken); end
    total++; if (pred_target !== 32'h80) begin bad++; $display("FAIL train_target: got %h expected 00000080", pred_target); end
    advance();
  endtask

  // Counter walk 10 -> 01 -> 00 -> 01 via NT, NT, T.
  task automatic test_counter_walk();
    bit              dir   [3] = '{1'b0, 1'b0, 1'b1};
    bit              exp_m [3] = '{1'b1, 1'b0, 1'b1};
    logic [XLEN-1:0] exp_r [3] = '{32'h104, 32'h104, 32'h80};
    for (int k = 0; k < 3; k++) begin
      ex_carried(32'h100, 1'b1, 1'b0, dir[k], 32'h80);
      if_pc = 32'h100;
      @(negedge clk);
      total++; if (mispredict !== exp_m[k]) begin bad++; $display("FAIL walk_misp[%0d]: got %b expected %b", k, mispredict, exp_m[k]); end
      total++; if (redirect_pc !== exp_r[k]) begin bad++; $display("FAIL walk_redirect[%0d]: got %h expected %h", k, redirect_pc, exp_r[k]); end
      advance();
      ex_idle();
      @(negedge clk);
      total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL walk_taken[%0d]: got %b expected 0", k, pred_taken); end
      total++; if (pred_target !== 32'h104) begin bad++; $display("FAIL walk_target[%0d]: got %h expected 00000104", k, pred_target); end
      advance();
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 5; k++) begin
      ex_carried(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
      if_pc = 32'h100;
      @(negedge clk);
      total++; if (mispredict !== m_misp()) begin bad++; $display("FAIL sat_misp[%0d]: got %b expected %b", k, mispredict, m_misp()); end
      advance();
    end
    ex_idle();
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_taken: got %b expected 1", pred_taken); end
    advance();
    // One not-taken from saturation still predicts taken; a second drops below.
    for (int k = 0; k < 2; k++) begin
      ex_carried(32'h100, 1'b1, 1'b0, 1'b0, 32'h80);
      advance();
      ex_idle();
      @(negedge clk);
      total++; if (pred_taken !== (k == 0)) begin bad++; $display("FAIL sat_nt_taken[%0d]: got %b expected %b", k, pred_taken, (k == 0)); end
      total++; if (pred_target !== ((k == 0) ? 32'h80 : 32'h104)) begin bad++; $display("FAIL sat_nt_target[%0d]: got %h", k, pred_target); end
      advance();
    end
  endtask

  task automatic test_alias();
    logic [XLEN-1:0] apc;
    apc = 32'h100 + ((1 << IDX_BITS) * 4 * (1 << TAG_BITS));
    ex_carried(32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    advance();
    ex_idle(); if_pc = apc;
    @(negedge clk);
    total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL alias_hit: got %b expected 1", pred_hit); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL alias_taken: got %b expected 1", pred_taken); end
    advance();
    set_ex(1'b1, apc, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h80);
    @(negedge clk);
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL alias_misp: got %b expected 1", mispredict); end
    total++; if (redirect_pc !== apc + 32'd4) begin bad++; $display("FAIL alias_redirect: got %h expected %h", redirect_pc, apc + 32'd4); end
    advance();
    ex_idle(); if_pc = 32'h100;
    @(negedge clk);
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL alias_cleared: got %b expected 0", pred_hit); end
    advance();
  endtask

  // Update and lookup of index 5 in the same cycle.
  task automatic test_same_cycle();
    set_ex(1'b1, 32'h14, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h18);
    if_pc = 32'h14;
    @(negedge clk);
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL same_old_hit: got %b expected 0", pred_hit); end
    total++; if (pred_target !== 32'h18) begin bad++; $display("FAIL same_old_target: got %h expected 00000018", pred_target); end
    total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL same_misp: got %b expected 1", mispredict); end
    advance();
    ex_idle();
    @(negedge clk);
    total++; if (pred_hit !== 1'b1) begin bad++; $display("FAIL same_new_hit: got %b expected 1", pred_hit); end
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL same_new_taken: got %b expected 1", pred_taken); end
    total++; if (pred_target !== 32'h200) begin bad++; $display("FAIL same_new_target: got %h expected 00000200", pred_target); end
    advance();
  endtask

`ifdef BP_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    total++; if (perf_lookups !== m_lookups) begin bad++; $display("FAIL perf_lookups: got %0d expected %0d", perf_lookups, m_lookups); end
    total++; if (perf_branches !== m_branches) begin bad++; $display("FAIL perf_branches: got %0d expected %0d", perf_branches, m_branches); end
    total++; if (perf_mispredicts !== m_mispredicts) begin bad++; $display("FAIL perf_misp: got %0d expected %0d", perf_mispredicts, m_mispredicts); end
    advance();
  endtask
`endif

  // Mid-cycle asynchronous reset wipes training at once.
  task automatic test_async_reset();
    ex_idle(); if_pc = 32'h14;
    #2 rst = 1'b1;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL areset_hit: got %b expected 0", pred_hit); end
    total++; if (pred_target !== 32'h18) begin bad++; $display("FAIL areset_target: got %h expected 00000018", pred_target); end
`ifdef BP_PERF_EN
    total++; if (perf_lookups !== 32'd0) begin bad++; $display("FAIL areset_perf: got %0d expected 0", perf_lookups); end
`endif
    model_clear();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [XLEN-1:0] pc, tgt;
    int kind;
    bit tk;
    for (int n = 0; n < 400; n++) begin
      pc   = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
      tgt  = $urandom & 32'hffff_fffc;
      kind = $urandom_range(0, 3);
      tk   = ($urandom_range(0, 1) == 1);
      if (kind == 0)      ex_carried(pc, 1'b0, 1'b0, tk, tgt);
      else if (kind == 1) ex_carried(pc, 1'b0, 1'b1, 1'b1, tgt);
      else                ex_carried(pc, 1'b1, 1'b0, tk, tgt);
      if ($urandom_range(0, 4) == 0) ex_valid = 1'b0;
      if ($urandom_range(0, 7) == 0) ex_pred_taken = ~ex_pred_taken;
      if ($urandom_range(0, 7) == 0) ex_pred_target = $urandom & 32'hffff_fffc;
      if_pc = 32'h1000 | (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 1)) << 8);
      @(negedge clk);
      total++; if (pred_hit !== m_hit(if_pc)) begin bad++; $display("FAIL rnd_hit[%0d]: got %b expected %b", n, pred_hit, m_hit(if_pc)); end
      total++; if (pred_taken !== m_taken(if_pc)) begin bad++; $display("FAIL rnd_taken[%0d]: got %b expected %b", n, pred_taken, m_taken(if_pc)); end
      total++; if (pred_target !== m_ptarget(if_pc)) begin bad++; $display("FAIL rnd_target[%0d]: got %h expected %h", n, pred_target, m_ptarget(if_pc)); end
      total++; if (mispredict !== m_misp()) begin bad++; $display("FAIL rnd_misp[%0d]: got %b expected %b", n, mispredict, m_misp()); end
      total++; if (redirect_pc !== m_redirect()) begin bad++; $display("FAIL rnd_redirect[%0d]: got %h expected %h", n, redirect_pc, m_redirect()); end
      advance();
    end
    ex_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    if_pc = '0;
    ex_idle();
    model_clear();
    test_reset();
    test_train_taken();
    test_counter_walk();
    test_saturation();
    test_alias();
    test_same_cycle();
`ifdef BP_PERF_EN
    test_perf();
`endif
    test_async_reset();
    test_random();
`ifdef BP_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline. Combines a direct-mapped branch target buffer with per-entry saturating direction counters. Looks up the fetch PC combinationally in IF and is trained by the resolved branch/jump in EX. Also generates the mispredict/redirect signal that replaces the static "branch resolved in EX, flush IF/ID" path.

## Interface
Parameters:
- XLEN, 32, address/data width
- IDX_BITS, 6, table index width; entries = 2^IDX_BITS
- TAG_BITS, 8, stored tag width
- CNT_BITS, 2, direction counter width (≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_pc  in  XLEN  fetch-stage PC
- pred_hit  out  1  valid entry with matching tag for if_pc
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  next fetch PC
- ex_valid  in  1  EX holds a real (non-bubble, non-stalled) instruction
- ex_pc  in  XLEN  PC of EX instruction
- ex_is_branch  in  1  conditional branch (beq/blt class)
- ex_is_jump  in  1  jal/jalr
- ex_taken  in  1  resolved direction (1 for jumps)
- ex_target  in  XLEN  resolved target (jalr already LSB-cleared)
- ex_pred_taken  in  1  pred_taken carried down the pipe with this instruction
- ex_pred_target  in  XLEN  pred_target carried down the pipe
- mispredict  out  1  flush IF/ID and ID/EX, load redirect_pc
- redirect_pc  out  XLEN  corrected PC
- perf_lookups, perf_branches, perf_mispredicts  out  32 each  present only with BP_PERF_EN

## Operation
- Index = pc[IDX_BITS+1:2]. Tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Entry fields: valid, tag, target[XLEN], jump bit, counter[CNT_BITS].
- Lookup (combinational):
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & (jump | counter MSB).
  - pred_target = pred_taken ? target : if_pc+4.
- Resolution:
  - act_taken = ex_valid & (ex_is_branch | ex_is_jump) & ex_taken.
  - mispredict = ex_valid & ((act_taken ≠ ex_pred_taken) | (act_taken & ex_target ≠ ex_pred_target)).
  - redirect_pc = act_taken ? ex_target : ex_pc+4.
  - mispredict = 0 whenever ex_valid = 0.
- Update, when ex_valid and (ex_is_branch | ex_is_jump):
  - Entry hits ex_pc: write target and jump bit. Counter saturating +1 if taken, −1 if not; holds at all-ones / all-zeros.
  - Entry misses and taken: allocate. valid=1, tag, target, jump bit. Counter = weakly taken (1 followed by zeros).
  - Entry misses and not taken: no write.
- Alias cleanup: ex_valid, not branch/jump, ex_pred_taken=1 means a false hit. Clear valid of the entry at that index (mispredict asserts, redirect ex_pc+4).
- Reset: all valid=0, counters = weakly not-taken (0 followed by ones), perf counters 0. Outputs right after reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4, mispredict=0.
- An asynchronous rst in mid-operation discards all training immediately.

## Timing
- Lookup: zero cycles, combinational from registered tables.
- Update: written on the clk edge at the end of the EX cycle; visible to lookup in the following cycle.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents.
- mispredict/redirect_pc: combinational in the EX cycle. The caller loads the PC on the next edge and flushes IF/ID and ID/EX (2-cycle penalty).
- The caller gates ex_valid low during stalls/bubbles, so no double training.

## Configuration
- BP_PERF_EN defined: three 32-bit counters, incremented at clk edge, wrapping modulo 2^32.
  - perf_lookups: +1 every cycle while not rst.
  - perf_branches: +1 per ex_valid branch/jump.
  - perf_mispredicts: +1 per mispredict.
- Undefined: ports and logic absent; predictor behaviour identical.

## Structure
- Package bp_pkg holds:
  - entry struct typedef (valid, tag, target, jump, cnt);
  - counter constants CNT_WEAK_T / CNT_WEAK_NT / CNT_MAX, as functions of CNT_BITS;
  - index/tag slice helper functions.
- One sub-module, bp_sat_counter: combinational next-value saturating inc/dec, CNT_BITS-parametrised, instantiated in the update path.

## Test plan
- Reset, if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, mispredict=0.
- Train beq at 0x100 taken to 0x80 (ex_pred_taken=0) -> mispredict=1, redirect 0x80. Next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Train same branch not-taken 2×, then taken 1× -> counters go 10→01→00→01. Lookup predicts not-taken; pred_target=0x104 at each point as applicable.
- Counter saturation: 5 consecutive taken -> counter holds 11. One not-taken -> still predicts taken.
- Alias: entry for 0x100. Non-branch at 0x100+(2^IDX_BITS·4·2^TAG_BITS) sharing index/tag with ex_pred_taken=1 -> mispredict, redirect pc+4, entry invalidated next cycle.
- Simultaneous lookup/update of index 5 -> lookup shows old entry; next cycle new. With BP_PERF_EN, counters match the scripted totals.
